// File: rtl/rnn_pkg.sv
// Shared constants, memory-select encodings and arbiter state type for the
// RNN memory subsystem.
package rnn_pkg;

  localparam int RNN_AW = 17;
  localparam int RNN_DW = 20;
  localparam int RNN_SW = 3;

  localparam logic [2:0] MSEL_W_IH = 3'b000;
  localparam logic [2:0] MSEL_W_HH = 3'b010;
  localparam logic [2:0] MSEL_B_IH = 3'b001;
  localparam logic [2:0] MSEL_B_HH = 3'b011;
  localparam logic [2:0] MSEL_T    = 3'b100;
  localparam logic [2:0] MSEL_OUT  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rnn_rr_pick2.sv
// Combinational two-way round-robin picker: when both request, the one named
// by ptr wins; otherwise the lone requester wins.
module rnn_rr_pick2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic       gnt,
  output logic       any
);

  always_comb begin
    any = |valid;
    gnt = (&valid) ? ptr : valid[1];
  end

endmodule

// File: rtl/rnn_mem_arbiter.sv
// Shares the single external RNN memory port between the weight/bias fetch
// engine (requester 0) and the hidden-state writeback engine (requester 1).
module rnn_mem_arbiter
  import rnn_pkg::*;
#(
  parameter int              AW     = RNN_AW,
  parameter int              DW     = RNN_DW,
  parameter int              SW     = RNN_SW,
  parameter logic [SW-1:0]   WR_SEL = SW'(MSEL_OUT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_last,
  input  logic [SW-1:0] req0_sel,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_last,
  input  logic [SW-1:0] req1_sel,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_data,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_data,
  output logic          mce,
  output logic [SW-1:0] msel,
  output logic [AW-1:0] maddr,
  output logic [DW-1:0] mdata_w,
  input  logic [DW-1:0] mdata_r
);

  arb_state_t    state;
  logic          ptr;
  logic          pick_gnt;
  logic          pick_any;
  logic          acc0;
  logic          acc1;
  logic          acc;
  logic          beat_wr;
  logic [SW-1:0] beat_sel;
  logic [AW-1:0] beat_addr;
  logic [DW-1:0] beat_wdata;
  logic          rsp_vld_p0;
  logic          rsp_tag_p0;
  logic          rsp_vld_p1;
  logic          rsp_tag_p1;

  rnn_rr_pick2 u_pick (
    .valid ({req1_valid, req0_valid}),
    .ptr   (ptr),
    .gnt   (pick_gnt),
    .any   (pick_any)
  );

  assign acc0 = req0_valid & req0_ready;
  assign acc1 = req1_valid & req1_ready;
  assign acc  = acc0 | acc1;

  // Only the owner's ready is ever high, so it doubles as the beat mux select.
  always_comb begin
    beat_sel   = req0_sel;
    beat_addr  = req0_addr;
    beat_wdata = req0_wdata;
    if (req1_ready) begin
      beat_sel   = req1_sel;
      beat_addr  = req1_addr;
      beat_wdata = req1_wdata;
    end
    beat_wr = (beat_sel == WR_SEL);
  end

  // Ownership FSM: grant changes only when the owner's last beat is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            state      <= pick_gnt ? OWN1 : OWN0;
            req0_ready <= ~pick_gnt;
            req1_ready <= pick_gnt;
          end
        end
        OWN0: begin
          if (acc0 && req0_last) begin
            ptr        <= 1'b1;
            req0_ready <= 1'b0;
            if (req1_valid) begin
              state      <= OWN1;
              req1_ready <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        OWN1: begin
          if (acc1 && req1_last) begin
            ptr        <= 1'b0;
            req1_ready <= 1'b0;
            if (req0_valid) begin
              state      <= OWN0;
              req0_ready <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state      <= IDLE;
          req0_ready <= 1'b0;
          req1_ready <= 1'b0;
        end
      endcase
    end
  end

  // Stage p0: memory strobe registered; read tag travels with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mce        <= 1'b0;
      msel       <= '0;
      maddr      <= '0;
      mdata_w    <= '0;
      rsp_vld_p0 <= 1'b0;
      rsp_tag_p0 <= 1'b0;
    end else begin
      mce        <= acc;
      rsp_vld_p0 <= acc & ~beat_wr;
      rsp_tag_p0 <= req1_ready;
      if (acc) begin
        msel    <= beat_sel;
        maddr   <= beat_addr;
        mdata_w <= beat_wdata;
      end
    end
  end

  // Stage p1: memory read data is valid now; route it to the issuing requester.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_vld_p1 <= 1'b0;
      rsp_tag_p1 <= 1'b0;
    end else begin
      rsp_vld_p1 <= rsp_vld_p0;
      rsp_tag_p1 <= rsp_tag_p0;
    end
  end

  assign rsp0_valid = rsp_vld_p1 & ~rsp_tag_p1;
  assign rsp1_valid = rsp_vld_p1 &  rsp_tag_p1;
  assign rsp0_data  = rsp0_valid ? mdata_r : '0;
  assign rsp1_data  = rsp1_valid ? mdata_r : '0;

endmodule
